// File: rtl/alu_stream.sv
// Two-stage streaming ALU with valid/ready handshakes on both sides, an
// accumulator, a sticky error flag and a saturating completed-op counter.
module alu_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [2:0]       i_oper,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_err_sticky,
  input  logic             i_clr_sticky,
  output logic [CNTW-1:0]  o_op_count
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_SUB   = 3'b000,
    OP_NAND  = 3'b001,
    OP_LONES = 3'b010,
    OP_OHDEC = 3'b011,
    OP_ADD   = 3'b100,
    OP_ACC   = 3'b101,
    OP_ACLR  = 3'b110,
    OP_RSV   = 3'b111
  } op_e;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flag_q;
  logic [WIDTH-1:0] acc_q;
  logic             sticky_q;
  logic [CNTW-1:0]  count_q;

  logic             s1_adv;
  logic             in_hs;
  logic             out_hs;

  logic [WIDTH-1:0] sum_add;
  logic [WIDTH-1:0] sum_sub;
  logic [WIDTH-1:0] sum_acc;
  logic [WIDTH-1:0] lones;
  logic [WIDTH-1:0] oh_idx;
  logic             oh_ok;
  logic             run;

  logic [WIDTH-1:0] result_d;
  logic [3:0]       flag_d;
  logic [WIDTH-1:0] acc_d;
  logic             err_d;
  logic             ovf_d;

  // Handshake control: stage 1 drains whenever stage 2 is empty or emitting.
  assign out_hs  = s2_valid_q & i_ready;
  assign o_ready = ~s1_valid_q | ~s2_valid_q | i_ready;
  assign s1_adv  = s1_valid_q & (~s2_valid_q | i_ready);
  assign in_hs   = i_valid & o_ready;

  assign sum_add = s1_a_q + s1_b_q;
  assign sum_sub = s1_a_q - s1_b_q;
  assign sum_acc = acc_q + s1_a_q;

  // Leading-ones count from the MSB and one-hot decode of operand A.
  always_comb begin
    lones  = '0;
    oh_idx = '0;
    run    = 1'b1;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (run && s1_a_q[i]) begin
        lones = lones + WIDTH'(1);
      end else begin
        run = 1'b0;
      end
      if (s1_a_q[i]) begin
        oh_idx = WIDTH'(i);
      end
    end
    oh_ok = (s1_a_q != '0) && ((s1_a_q & (s1_a_q - WIDTH'(1))) == '0);
  end

  // Stage-2 result, flags and accumulator next value.
  always_comb begin
    result_d = '0;
    err_d    = 1'b0;
    ovf_d    = 1'b0;
    acc_d    = acc_q;
    case (s1_op_q)
      OP_SUB: begin
        result_d = sum_sub;
        ovf_d    = (s1_a_q[MSB] != s1_b_q[MSB]) && (sum_sub[MSB] != s1_a_q[MSB]);
      end
      OP_NAND:  result_d = ~(s1_a_q & s1_b_q);
      OP_LONES: result_d = lones;
      OP_OHDEC: begin
        result_d = oh_ok ? oh_idx : '0;
        err_d    = ~oh_ok;
      end
      OP_ADD: begin
        result_d = sum_add;
        ovf_d    = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum_add[MSB] != s1_a_q[MSB]);
      end
      OP_ACC: begin
        result_d = sum_acc;
        acc_d    = sum_acc;
        ovf_d    = (acc_q[MSB] == s1_a_q[MSB]) && (sum_acc[MSB] != acc_q[MSB]);
      end
      OP_ACLR: begin
        result_d = '0;
        acc_d    = '0;
      end
      default: err_d = 1'b1;
    endcase
    flag_d = {ovf_d,
              ~err_d & (result_d != '0) & ~result_d[MSB],
              ~err_d & result_d[MSB],
              err_d};
  end

  // Stage 1: operand capture.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_SUB;
    end else begin
      if (o_ready) begin
        s1_valid_q <= i_valid;
      end
      if (in_hs) begin
        s1_a_q  <= i_arg0;
        s1_b_q  <= i_arg1;
        s1_op_q <= op_e'(i_oper);
      end
    end
  end

  // Stage 2: result register, accumulator, sticky error and op counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flag_q     <= '0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        result_q   <= result_d;
        flag_q     <= flag_d;
        acc_q      <= acc_d;
      end else if (out_hs) begin
        s2_valid_q <= 1'b0;
      end
      if (out_hs && flag_q[0]) begin
        sticky_q <= 1'b1;
      end else if (i_clr_sticky) begin
        sticky_q <= 1'b0;
      end
      if (out_hs && (count_q != '1)) begin
        count_q <= count_q + CNTW'(1);
      end
    end
  end

  assign o_valid      = s2_valid_q;
  assign o_result     = result_q;
  assign o_flag       = flag_q;
  assign o_acc        = acc_q;
  assign o_err_sticky = sticky_q;
  assign o_op_count   = count_q;

endmodule

// File: tb/tb_alu_stream.sv
// Table-driven, scoreboarded bench for alu_stream (WIDTH=8, CNTW=16).
module tb_alu_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_arg0 = '0;
  logic [7:0]  i_arg1 = '0;
  logic [2:0]  i_oper = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [7:0]  o_result;
  logic [3:0]  o_flag;
  logic [7:0]  o_acc;
  logic        o_err_sticky;
  logic        i_clr_sticky = 1'b0;
  logic [15:0] o_op_count;

  alu_stream #(.WIDTH(8), .CNTW(16)) dut (
    .i_clk(clk), .i_rstn(rst_n), .i_arg0(i_arg0), .i_arg1(i_arg1),
    .i_oper(i_oper), .i_valid(i_valid), .o_ready(o_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_flag(o_flag), .o_acc(o_acc),
    .o_err_sticky(o_err_sticky), .i_clr_sticky(i_clr_sticky),
    .o_op_count(o_op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [3:0] flag;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flag;
  } exp_t;

  vec_t vecs [18];
  exp_t q [$];
  int   errors = 0;
  int   checks = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_res;
  logic [3:0] prev_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one op; queue its expected output in the cycle it is accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] r, input logic [3:0] f);
    int   n;
    logic done;
    exp_t e;
    n = 0;
    done = 1'b0;
    i_arg0 = a; i_arg1 = b; i_oper = op; i_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (o_ready) begin
        e.res = r; e.flag = f;
        q.push_back(e);
        done = 1'b1;
      end else begin
        n++;
        if (n > 50) begin
          checks++; errors++;
          $display("FAIL send_timeout: op %0h not accepted", op);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard compare on handshake, stability check under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(o_valid), 32'(1'b1));
        chk("hold_result", 32'(o_result), 32'(prev_res));
        chk("hold_flag", 32'(o_flag), 32'(prev_flag));
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h expected none", o_result);
        end else begin
          e = q.pop_front();
          chk("result", 32'(o_result), 32'(e.res));
          chk("flag", 32'(o_flag), 32'(e.flag));
        end
      end
      stall_prev = o_valid && !i_ready;
      prev_res   = o_result;
      prev_flag  = o_flag;
    end
  end

  initial begin
    vecs[0]  = '{8'h05, 8'h07, 3'b000, 8'hFE, 4'b0010};
    vecs[1]  = '{8'h80, 8'h01, 3'b000, 8'h7F, 4'b1100};
    vecs[2]  = '{8'h00, 8'h00, 3'b100, 8'h00, 4'b0000};
    vecs[3]  = '{8'hF0, 8'h3C, 3'b001, 8'hCF, 4'b0010};
    vecs[4]  = '{8'hE5, 8'h00, 3'b010, 8'h03, 4'b0100};
    vecs[5]  = '{8'hFF, 8'h12, 3'b010, 8'h08, 4'b0100};
    vecs[6]  = '{8'h7F, 8'h00, 3'b010, 8'h00, 4'b0000};
    vecs[7]  = '{8'h20, 8'hFF, 3'b011, 8'h05, 4'b0100};
    vecs[8]  = '{8'h06, 8'h00, 3'b011, 8'h00, 4'b0001};
    vecs[9]  = '{8'h00, 8'h00, 3'b011, 8'h00, 4'b0001};
    vecs[10] = '{8'h7F, 8'h01, 3'b100, 8'h80, 4'b1010};
    vecs[11] = '{8'hFF, 8'h01, 3'b100, 8'h00, 4'b0000};
    vecs[12] = '{8'h12, 8'h34, 3'b111, 8'h00, 4'b0001};
    vecs[13] = '{8'h55, 8'h00, 3'b110, 8'h00, 4'b0000};
    vecs[14] = '{8'h10, 8'h00, 3'b101, 8'h10, 4'b0100};
    vecs[15] = '{8'h70, 8'h00, 3'b101, 8'h80, 4'b1010};
    vecs[16] = '{8'h00, 8'h80, 3'b000, 8'h80, 4'b1010};
    vecs[17] = '{8'h80, 8'h00, 3'b011, 8'h07, 4'b0100};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", 32'(o_valid), 32'(1'b0));
    chk("rst_ready", 32'(o_ready), 32'(1'b1));
    chk("rst_result", 32'(o_result), 32'(8'h00));
    chk("rst_flag", 32'(o_flag), 32'(4'h0));
    chk("rst_acc", 32'(o_acc), 32'(8'h00));
    chk("rst_sticky", 32'(o_err_sticky), 32'(1'b0));
    chk("rst_count", 32'(o_op_count), 32'(16'h0));

    // Two-cycle latency
    send(8'h05, 8'h07, 3'b000, 8'hFE, 4'b0010);
    @(negedge clk);
    chk("lat_n1_valid", 32'(o_valid), 32'(1'b0));
    @(negedge clk);
    chk("lat_n2_valid", 32'(o_valid), 32'(1'b1));
    @(posedge clk); #1;

    // Back-to-back table at full throughput
    for (int i = 0; i < 18; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flag);
    end
    drain();
    chk("table_count", 32'(o_op_count), 32'(16'd19));
    chk("table_acc", 32'(o_acc), 32'(8'h80));
    chk("table_sticky", 32'(o_err_sticky), 32'(1'b1));

    // Sticky clear, then set wins over a held clear
    i_clr_sticky = 1'b1;
    @(posedge clk); #1;
    chk("sticky_clr", 32'(o_err_sticky), 32'(1'b0));
    send(8'h06, 8'h00, 3'b011, 8'h00, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("sticky_set_wins", 32'(o_err_sticky), 32'(1'b1));
    @(negedge clk);
    chk("sticky_clr_after", 32'(o_err_sticky), 32'(1'b0));
    i_clr_sticky = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset with both stages full
    i_ready = 1'b0;
    send(8'h01, 8'h01, 3'b100, 8'h02, 4'b0100);
    send(8'h02, 8'h02, 3'b100, 8'h04, 4'b0100);
    @(negedge clk);
    chk("pre_rst_valid", 32'(o_valid), 32'(1'b1));
    chk("pre_rst_ready", 32'(o_ready), 32'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'(1'b0));
    chk("arst_acc", 32'(o_acc), 32'(8'h00));
    chk("arst_count", 32'(o_op_count), 32'(16'h0));
    q.delete();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rel_ready", 32'(o_ready), 32'(1'b1));

    // Backpressure: three ops offered, two accepted, then released in order
    i_arg0 = 8'h09; i_arg1 = 8'h02; i_oper = 3'b000; i_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready1", 32'(o_ready), 32'(1'b1));
    q.push_back('{8'h07, 4'b0100});
    @(posedge clk); #1;
    i_arg0 = 8'hFF; i_arg1 = 8'hFF; i_oper = 3'b001;
    @(negedge clk);
    chk("bp_ready2", 32'(o_ready), 32'(1'b1));
    q.push_back('{8'h00, 4'b0000});
    @(posedge clk); #1;
    i_arg0 = 8'hC0; i_arg1 = 8'h00; i_oper = 3'b010;
    @(negedge clk);
    chk("bp_ready3", 32'(o_ready), 32'(1'b0));
    chk("bp_held_result", 32'(o_result), 32'(8'h07));
    repeat (3) @(posedge clk);
    #1 i_ready = 1'b1;
    send(8'hC0, 8'h00, 3'b010, 8'h02, 4'b0100);
    drain();
    chk("bp_count", 32'(o_op_count), 32'(16'd3));
    chk("bp_idle", 32'(o_valid), 32'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
